// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder and the main control decoder:
// instruction kinds, MIPS opcodes, the NOP word and the encoder state encoding.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_J    = 3'd4,
        KIND_LUI  = 3'd5,
        KIND_ORI  = 3'd6,
        KIND_ADDI = 3'd7
    } kind_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // sll $0, $0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: instruction kind plus fields -> 32-bit MIPS word.
// Fields a kind does not use are ignored.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word
);

    always_comb begin
        word = NOP_WORD;
        case (kind_t'(kind))
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_J:    word = {OP_J, target};
            // LUI has no source register; the rs field is forced to zero
            KIND_LUI:  word = {OP_LUI, 5'd0, rt, imm};
            KIND_ORI:  word = {OP_ORI, rs, rt, imm};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            default:   word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams instruction intents into instruction memory as packed MIPS words.
// Define ENC_NOP_PAD_EN to fill the slots after the last word with NOPs.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned       DEPTH     = 64,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    localparam int unsigned       SLOT_W    = $clog2(DEPTH + 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(DEPTH);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DEPTH - 1);

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              accept;

    instr_pack u_pack (
        .kind   (in_kind),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .word   (word)
    );

    // Handshake: a word transfers on any rising edge where in_valid && in_ready.
    assign in_ready = (state == ST_LOAD) && (slot < SLOT_MAX);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_LOAD) || (state == ST_PAD);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            slot       <= '0;
            ptr        <= BASE_ADDR;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            count      <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        slot  <= '0;
                        ptr   <= BASE_ADDR;
                        count <= '0;
                        err   <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ptr;
                        imem_wdata <= word;
                        ptr        <= ptr + ADDR_W'(4);
                        slot       <= slot + 1'b1;
                        count      <= count + 1'b1;
                        if (in_last) begin
`ifdef ENC_NOP_PAD_EN
                            if (slot == SLOT_LAST) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_PAD;
                            end
`else
                            state <= ST_DONE;
                            done  <= 1'b1;
`endif
                        end else if (slot == SLOT_LAST) begin
                            // memory full before the program ended
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
`ifdef ENC_NOP_PAD_EN
                ST_PAD: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= NOP_WORD;
                    ptr        <= ptr + ADDR_W'(4);
                    slot       <= slot + 1'b1;
                    count      <= count + 1'b1;
                    if (slot == SLOT_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
